// File: rtl/ay_bus_pkg.sv
// rtl/ay_bus_pkg.sv - shared types and constants for the AY PSG bus master
package ay_bus_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LATCH = 3'd1,
    GAP1  = 3'd2,
    WRITE = 3'd3,
    GAP2  = 3'd4
  } state_t;

  // {bdir, bc1}; 2'b01 is a PSG read and is never driven by this master
  localparam logic [1:0] BUS_INACTIVE = 2'b00;
  localparam logic [1:0] BUS_WRITE    = 2'b10;
  localparam logic [1:0] BUS_LATCH    = 2'b11;

  localparam logic [3:0] R0  = 4'd0;
  localparam logic [3:0] R1  = 4'd1;
  localparam logic [3:0] R2  = 4'd2;
  localparam logic [3:0] R3  = 4'd3;
  localparam logic [3:0] R4  = 4'd4;
  localparam logic [3:0] R5  = 4'd5;
  localparam logic [3:0] R6  = 4'd6;
  localparam logic [3:0] R7  = 4'd7;
  localparam logic [3:0] R8  = 4'd8;
  localparam logic [3:0] R9  = 4'd9;
  localparam logic [3:0] R10 = 4'd10;
  localparam logic [3:0] R11 = 4'd11;
  localparam logic [3:0] R12 = 4'd12;
  localparam logic [3:0] R13 = 4'd13;

  typedef struct packed {
    logic [3:0] addr;
    logic [7:0] data;
  } req_t;

endpackage

// File: rtl/ay_bus_fifo.sv
// rtl/ay_bus_fifo.sv - synchronous request FIFO with full/empty flags
module ay_bus_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == FULL_COUNT);
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // DEPTH is a power of two, so plain pointer overflow is the modulo wrap
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ay_bus_master.sv
// rtl/ay_bus_master.sv - queues register writes and plays them onto the AY PSG bus
module ay_bus_master
  import ay_bus_pkg::*;
#(
  parameter logic [3:0] DA7_DA4_UPPER_ADDRESS_MASK = 4'b0000,
  parameter int         PHASE_CYCLES               = 2,
  parameter int         FIFO_DEPTH                 = 4,
  parameter bit         SKIP_RELATCH               = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_addr,
  input  logic [7:0] req_data,
  output logic       bdir,
  output logic       bc1,
  output logic [7:0] bus_data,
  output logic       busy
);

  localparam logic [3:0] PHASE_LAST = 4'(PHASE_CYCLES - 1);

  state_t     state, state_next;
  logic [3:0] phase_cnt, phase_next;
  logic [3:0] cur_addr, cur_addr_next;
  logic [7:0] cur_data, cur_data_next;
  logic [3:0] last_addr, last_addr_next;
  logic       last_valid, last_valid_next;
  logic [1:0] bus_ctl_next;
  logic [7:0] bus_data_next;

  req_t req_in;
  req_t fifo_head;
  logic fifo_full;
  logic fifo_empty;
  logic fifo_push;
  logic fifo_pop;
  logic take_head;
  logic relatch_skip;

  assign req_in.addr = req_addr;
  assign req_in.data = req_data;
  assign req_ready   = !fifo_full;
  assign fifo_push   = req_valid && req_ready;
  assign busy        = !fifo_empty || (state != IDLE);

  ay_bus_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(req_t))
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (req_in),
    .full      (fifo_full),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .empty     (fifo_empty)
  );

  // The PSG keeps its latched address, so a repeat write can go straight to WRITE
  assign relatch_skip = SKIP_RELATCH && last_valid && (last_addr == fifo_head.addr);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      phase_cnt  <= '0;
      cur_addr   <= '0;
      cur_data   <= '0;
      last_addr  <= '0;
      last_valid <= 1'b0;
      bdir       <= 1'b0;
      bc1        <= 1'b0;
      bus_data   <= 8'h00;
    end else begin
      state         <= state_next;
      phase_cnt     <= phase_next;
      cur_addr      <= cur_addr_next;
      cur_data      <= cur_data_next;
      last_addr     <= last_addr_next;
      last_valid    <= last_valid_next;
      {bdir, bc1}   <= bus_ctl_next;
      bus_data      <= bus_data_next;
    end
  end

  always_comb begin
    state_next      = state;
    phase_next      = phase_cnt;
    cur_addr_next   = cur_addr;
    cur_data_next   = cur_data;
    last_addr_next  = last_addr;
    last_valid_next = last_valid;
    take_head       = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) take_head = 1'b1;
      end
      LATCH: begin
        if (phase_cnt == PHASE_LAST) begin
          state_next      = GAP1;
          last_addr_next  = cur_addr;
          last_valid_next = 1'b1;
        end else begin
          phase_next = phase_cnt + 4'd1;
        end
      end
      GAP1: begin
        state_next = WRITE;
        phase_next = '0;
      end
      WRITE: begin
        if (phase_cnt == PHASE_LAST) state_next = GAP2;
        else                         phase_next = phase_cnt + 4'd1;
      end
      GAP2: begin
        if (!fifo_empty) take_head = 1'b1;
        else             state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (take_head) begin
      cur_addr_next = fifo_head.addr;
      cur_data_next = fifo_head.data;
      phase_next    = '0;
      state_next    = relatch_skip ? WRITE : LATCH;
    end
  end

  assign fifo_pop = take_head;

  // Bus values are computed from the next state so the registered pins line up with it
  always_comb begin
    bus_ctl_next  = BUS_INACTIVE;
    bus_data_next = 8'h00;
    case (state_next)
      LATCH: begin
        bus_ctl_next  = BUS_LATCH;
        bus_data_next = {DA7_DA4_UPPER_ADDRESS_MASK, cur_addr_next};
      end
      WRITE: begin
        bus_ctl_next  = BUS_WRITE;
        bus_data_next = cur_data_next;
      end
      GAP1, GAP2: begin
        bus_ctl_next  = BUS_INACTIVE;
        bus_data_next = bus_data;
      end
      default: begin
        bus_ctl_next  = BUS_INACTIVE;
        bus_data_next = 8'h00;
      end
    endcase
  end

endmodule

// File: tb/tb_ay_bus_master.sv
// tb/tb_ay_bus_master.sv - randomized self-checking bench for ay_bus_master
module tb_ay_bus_master;
  import ay_bus_pkg::*;

  localparam int         P    = 2;
  localparam logic [3:0] MASK = 4'h0;

  typedef struct {
    logic [1:0] ctl;
    logic [7:0] data;
    logic       busy;
  } beat_t;

  typedef struct {
    logic [3:0] addr;
    logic [7:0] data;
  } wr_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_valid_b = 1'b0;
  logic [3:0] req_addr = 4'h0;
  logic [7:0] req_data = 8'h00;
  logic       req_ready, req_ready_b;
  logic       bdir, bc1, bdir_b, bc1_b;
  logic [7:0] bus_data, bus_data_b;
  logic       busy, busy_b;

  int tests = 0;
  int fails = 0;

  beat_t exp_q[$];
  beat_t exp2_q[$];
  wr_t   bq[$];
  wr_t   log_q[$];
  logic       m_cache_v = 1'b0;
  logic [3:0] m_cache_a = 4'h0;
  logic [7:0] rx_regs [16];
  logic [3:0] rx_addr = 4'h0;
  logic [1:0] prev_ctl = 2'b00;
  int         illegal_cnt = 0;
  bit         stall_seen;
  int         acc_before_stall;

  always #5 clk = ~clk;

  ay_bus_master #(
    .DA7_DA4_UPPER_ADDRESS_MASK(MASK), .PHASE_CYCLES(P), .FIFO_DEPTH(4), .SKIP_RELATCH(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .bdir(bdir), .bc1(bc1),
    .bus_data(bus_data), .busy(busy)
  );

  ay_bus_master #(
    .DA7_DA4_UPPER_ADDRESS_MASK(MASK), .PHASE_CYCLES(P), .FIFO_DEPTH(4), .SKIP_RELATCH(1'b0)
  ) dut_b (
    .clk(clk), .reset(reset), .req_valid(req_valid_b), .req_ready(req_ready_b),
    .req_addr(req_addr), .req_data(req_data), .bdir(bdir_b), .bc1(bc1_b),
    .bus_data(bus_data_b), .busy(busy_b)
  );

  // Receiver: a PSG-like register file decoded from the bus pins
  always @(negedge clk) begin
    if (!reset) begin
      if ({bdir, bc1} == 2'b01) illegal_cnt++;
      if ({bdir, bc1} == 2'b11) rx_addr = bus_data[3:0];
      if ({bdir, bc1} == 2'b10 && prev_ctl != 2'b10) begin
        rx_regs[rx_addr] = bus_data;
        log_q.push_back('{addr: rx_addr, data: bus_data});
      end
      prev_ctl = {bdir, bc1};
    end else begin
      prev_ctl = 2'b00;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic mdl_start(input bit use_b);
    exp_q.delete();
    exp2_q.delete();
    exp_q.push_back('{ctl: 2'b00, data: 8'h00, busy: 1'b1});
    if (use_b) exp2_q.push_back('{ctl: 2'b00, data: 8'h00, busy: 1'b1});
  endtask

  task automatic mdl_end(input bit use_b);
    exp_q.push_back('{ctl: 2'b00, data: 8'h00, busy: 1'b0});
    if (use_b) exp2_q.push_back('{ctl: 2'b00, data: 8'h00, busy: 1'b0});
  endtask

  // One write as it should appear on the bus when the master never goes idle in between
  task automatic mdl_txn(input logic [3:0] a, input logic [7:0] d, input bit use_b);
    if (!(m_cache_v && m_cache_a == a)) begin
      repeat (P) exp_q.push_back('{ctl: 2'b11, data: {MASK, a}, busy: 1'b1});
      exp_q.push_back('{ctl: 2'b00, data: {MASK, a}, busy: 1'b1});
      m_cache_v = 1'b1;
      m_cache_a = a;
    end
    repeat (P) exp_q.push_back('{ctl: 2'b10, data: d, busy: 1'b1});
    exp_q.push_back('{ctl: 2'b00, data: d, busy: 1'b1});
    if (use_b) begin
      repeat (P) exp2_q.push_back('{ctl: 2'b11, data: {MASK, a}, busy: 1'b1});
      exp2_q.push_back('{ctl: 2'b00, data: {MASK, a}, busy: 1'b1});
      repeat (P) exp2_q.push_back('{ctl: 2'b10, data: d, busy: 1'b1});
      exp2_q.push_back('{ctl: 2'b00, data: d, busy: 1'b1});
    end
  endtask

  task automatic drive_burst(input bit use_b, input int gap_max);
    int  idx;
    int  guard;
    bit  rdy;
    int  gap;
    idx = 0;
    guard = 0;
    stall_seen = 0;
    acc_before_stall = 0;
    while (idx < bq.size() && guard < 400) begin
      @(negedge clk);
      req_valid = 1'b1;
      req_valid_b = use_b;
      req_addr = bq[idx].addr;
      req_data = bq[idx].data;
      rdy = req_ready;
      if (!rdy && !stall_seen) begin
        stall_seen = 1;
        acc_before_stall = idx;
      end
      @(posedge clk);
      guard++;
      if (rdy) begin
        idx++;
        if (gap_max > 0 && idx < bq.size()) begin
          gap = int'($urandom_range(0, gap_max));
          repeat (gap) begin
            @(negedge clk);
            req_valid = 1'b0;
            req_valid_b = 1'b0;
            @(posedge clk);
          end
        end
      end
    end
    @(negedge clk);
    req_valid = 1'b0;
    req_valid_b = 1'b0;
    if (idx < bq.size()) begin
      tests++;
      fails++;
      $display("FAIL drive_timeout: accepted %0d of %0d requests", idx, bq.size());
    end
  endtask

  task automatic check_trace(input string name);
    int n;
    n = (exp_q.size() > exp2_q.size()) ? exp_q.size() : exp2_q.size();
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      if (i < exp_q.size()) begin
        tests++;
        if ({bdir, bc1} !== exp_q[i].ctl || bus_data !== exp_q[i].data || busy !== exp_q[i].busy) begin
          fails++;
          $display("FAIL %s cycle %0d: got ctl=%b data=%h busy=%b, expected ctl=%b data=%h busy=%b",
                   name, i, {bdir, bc1}, bus_data, busy, exp_q[i].ctl, exp_q[i].data, exp_q[i].busy);
        end
      end
      if (i < exp2_q.size()) begin
        tests++;
        if ({bdir_b, bc1_b} !== exp2_q[i].ctl || bus_data_b !== exp2_q[i].data || busy_b !== exp2_q[i].busy) begin
          fails++;
          $display("FAIL %s_norelatch cycle %0d: got ctl=%b data=%h busy=%b, expected ctl=%b data=%h busy=%b",
                   name, i, {bdir_b, bc1_b}, bus_data_b, busy_b, exp2_q[i].ctl, exp2_q[i].data, exp2_q[i].busy);
        end
      end
    end
  endtask

  task automatic run_traced(input string name, input bit use_b);
    fork
      drive_burst(use_b, 0);
      begin
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        check_trace(name);
      end
    join
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    req_valid = 1'b0;
    req_valid_b = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if ({bdir, bc1, bus_data, busy, req_ready} !== {2'b00, 8'h00, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL reset_state: got ctl=%b data=%h busy=%b ready=%b, expected 00/00 busy=0 ready=1",
               {bdir, bc1}, bus_data, busy, req_ready);
    end
    tests++;
    if ({bdir_b, bc1_b, bus_data_b, busy_b, req_ready_b} !== {2'b00, 8'h00, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL reset_state_b: got ctl=%b data=%h busy=%b ready=%b, expected 00/00 busy=0 ready=1",
               {bdir_b, bc1_b}, bus_data_b, busy_b, req_ready_b);
    end
    reset = 1'b0;
    m_cache_v = 1'b0;
  endtask

  task automatic test_single();
    bq.delete();
    bq.push_back('{addr: 4'd7, data: 8'h38});
    mdl_start(0);
    mdl_txn(4'd7, 8'h38, 0);
    mdl_end(0);
    run_traced("single", 0);
  endtask

  task automatic test_skip();
    bq.delete();
    bq.push_back('{addr: 4'd8, data: 8'h0F});
    bq.push_back('{addr: 4'd8, data: 8'h1F});
    mdl_start(1);
    mdl_txn(4'd8, 8'h0F, 1);
    mdl_txn(4'd8, 8'h1F, 1);
    mdl_end(1);
    run_traced("skip", 1);
    repeat (4) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [3:0] a;
    bq.delete();
    mdl_start(0);
    for (int k = 0; k < 6; k++) begin
      a = 4'($urandom_range(0, 15));
      while (k == 0 && m_cache_v && a == m_cache_a) a = 4'($urandom_range(0, 15));
      bq.push_back('{addr: a, data: 8'($urandom)});
      mdl_txn(a, bq[k].data, 0);
    end
    mdl_end(0);
    run_traced("back_to_back", 0);
    tests++;
    if (!stall_seen || acc_before_stall != 5) begin
      fails++;
      $display("FAIL backpressure: stall_seen=%0d accepted_before_stall=%0d, expected stall after 5 (4 queued + 1 popped)",
               stall_seen, acc_before_stall);
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    bq.delete();
    bq.push_back('{addr: 4'd13, data: 8'h0E});
    bq.push_back('{addr: 4'd1, data: 8'h55});
    bq.push_back('{addr: 4'd2, data: 8'h66});
    drive_burst(0, 0);
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      if ({bdir, bc1} == 2'b10 && bus_data == 8'h0E) found = 1;
      else @(negedge clk);
    end
    tests++;
    if (!found) begin
      fails++;
      $display("FAIL reset_mid_wait: write of 0x0E never seen, got ctl=%b data=%h", {bdir, bc1}, bus_data);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_cache_v = 1'b0;
    tests++;
    if ({bdir, bc1, bus_data, busy, req_ready} !== {2'b00, 8'h00, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL reset_mid_abort: got ctl=%b data=%h busy=%b ready=%b, expected 00/00 busy=0 ready=1",
               {bdir, bc1}, bus_data, busy, req_ready);
    end
    repeat (8) @(negedge clk);
    tests++;
    if ({bdir, bc1, bus_data, busy} !== {2'b00, 8'h00, 1'b0}) begin
      fails++;
      $display("FAIL reset_mid_discard: got ctl=%b data=%h busy=%b, expected idle 00/00 busy=0",
               {bdir, bc1}, bus_data, busy);
    end
    bq.delete();
    bq.push_back('{addr: 4'd13, data: 8'h0A});
    mdl_start(0);
    mdl_txn(4'd13, 8'h0A, 0);
    mdl_end(0);
    run_traced("reset_mid_relatch", 0);
  endtask

  task automatic test_program_psg();
    for (int r = 0; r < 16; r++) rx_regs[r] = 8'hA5;
    bq.delete();
    bq.push_back('{addr: R0, data: 8'hFE});
    bq.push_back('{addr: R1, data: 8'h00});
    bq.push_back('{addr: R7, data: 8'h3E});
    bq.push_back('{addr: R8, data: 8'h0F});
    drive_burst(0, 0);
    for (int k = 0; k < 100 && busy; k++) @(negedge clk);
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL program_idle: busy=%b after wait, expected 0", busy);
    end
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (rx_regs[bq[k].addr] !== bq[k].data) begin
        fails++;
        $display("FAIL program_reg R%0d: got %h, expected %h", bq[k].addr, rx_regs[bq[k].addr], bq[k].data);
      end
    end
  endtask

  task automatic test_random();
    int n;
    for (int round = 0; round < 5; round++) begin
      log_q.delete();
      bq.delete();
      n = int'($urandom_range(3, 9));
      for (int k = 0; k < n; k++)
        bq.push_back('{addr: 4'($urandom_range(0, 3)), data: 8'($urandom)});
      drive_burst(0, (round % 2 == 0) ? 0 : 6);
      for (int k = 0; k < 300 && busy; k++) @(negedge clk);
      tests++;
      if (log_q.size() != n || busy !== 1'b0) begin
        fails++;
        $display("FAIL random_count round %0d: got %0d writes busy=%b, expected %0d writes busy=0",
                 round, log_q.size(), busy, n);
      end
      for (int k = 0; k < n && k < log_q.size(); k++) begin
        tests++;
        if (log_q[k].addr !== bq[k].addr || log_q[k].data !== bq[k].data) begin
          fails++;
          $display("FAIL random_order round %0d item %0d: got R%0d=%h, expected R%0d=%h",
                   round, k, log_q[k].addr, log_q[k].data, bq[k].addr, bq[k].data);
        end
      end
    end
    tests++;
    if (illegal_cnt != 0) begin
      fails++;
      $display("FAIL read_encoding: saw {bdir,bc1}=01 on %0d cycles, expected 0", illegal_cnt);
    end
  endtask

  initial begin
    for (int r = 0; r < 16; r++) rx_regs[r] = 8'h00;
    test_reset();
    test_single();
    test_skip();
    test_back_to_back();
    test_reset_mid();
    test_program_psg();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
